// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store using a request/grant/response
// handshake. Data requests have priority, but a streak limit stops fetch from starving.
// Optional grant counters are added when MEM_PORT_ARBITER_STATS_EN is defined.
module mem_port_arbiter #(
  parameter int unsigned MAX_DATA_STREAK = 4,
  parameter int unsigned STREAK_W        = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [3:0]  d_be,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [31:0] d_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata
`ifdef MEM_PORT_ARBITER_STATS_EN
  ,
  output logic [31:0] stat_if_cnt,
  output logic [31:0] stat_d_cnt
`endif
);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  localparam logic [STREAK_W-1:0] MaxStreak = STREAK_W'(MAX_DATA_STREAK);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 1 = data owns the port
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [31:0]         if_rdata_q, d_rdata_q;
  logic                data_win;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    streak_d    = streak_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_be_d    = mem_be_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    data_win    = 1'b0;
    if_gnt      = 1'b0;
    d_gnt       = 1'b0;
    if_rvalid   = 1'b0;
    d_rvalid    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (if_req || d_req) begin
          data_win  = d_req && !(if_req && (streak_q >= MaxStreak));
          owner_d   = data_win;
          state_d   = StReq;
          mem_req_d = 1'b1;
          if (data_win) begin
            mem_we_d    = d_we;
            mem_be_d    = d_be;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            // Only contested data wins count towards the streak.
            if (if_req) begin
              if (streak_q < MaxStreak) streak_d = streak_q + 1'b1;
            end else begin
              streak_d = '0;
            end
          end else begin
            mem_we_d    = 1'b0;
            mem_be_d    = 4'hF;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            streak_d    = '0;
          end
        end
      end
      StReq: begin
        if (mem_gnt) begin
          if_gnt    = ~owner_q;
          d_gnt     = owner_q;
          mem_req_d = 1'b0;
          state_d   = StWait;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          if_rvalid = ~owner_q;
          d_rvalid  = owner_q;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      streak_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      streak_q    <= streak_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      if (if_rvalid) if_rdata_q <= mem_rdata;
      if (d_rvalid)  d_rdata_q  <= mem_rdata;
    end
  end

  // Response data is forwarded in the rvalid cycle and held afterwards.
  assign if_rdata  = if_rvalid ? mem_rdata : if_rdata_q;
  assign d_rdata   = d_rvalid ? mem_rdata : d_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_be    = mem_be_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] stat_if_cnt_q, stat_d_cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_if_cnt_q <= '0;
      stat_d_cnt_q  <= '0;
    end else begin
      if (if_gnt) stat_if_cnt_q <= stat_if_cnt_q + 32'd1;
      if (d_gnt)  stat_d_cnt_q  <= stat_d_cnt_q + 32'd1;
    end
  end

  assign stat_if_cnt = stat_if_cnt_q;
  assign stat_d_cnt  = stat_d_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a transaction table with hand-computed expectations, plus
// sequences for contention, async reset and (when MEM_PORT_ARBITER_STATS_EN is set) grant counters.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, if_gnt, if_rvalid;
  logic [31:0] if_addr, if_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [3:0]  d_be;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_gnt, mem_rvalid;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef MEM_PORT_ARBITER_STATS_EN
  logic [31:0] stat_if_cnt, stat_d_cnt;
`endif

  mem_port_arbiter #(
    .MAX_DATA_STREAK(4),
    .STREAK_W       (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rvalid  (if_rvalid),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_be       (d_be),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rvalid   (d_rvalid),
    .d_rdata    (d_rdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_be     (mem_be),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
`ifdef MEM_PORT_ARBITER_STATS_EN
    ,
    .stat_if_cnt(stat_if_cnt),
    .stat_d_cnt (stat_d_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        is_data;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int unsigned stall;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
  } vec_t;

  localparam int NumVec = 5;
  vec_t        vecs[NumVec];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] last_if_rdata = '0;
  logic [31:0] last_d_rdata  = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic chk_payload(input string tag, input vec_t v);
    chk({tag, "_mem_req"}, mem_req, 1);
    chk({tag, "_mem_we"}, mem_we, v.exp_we);
    chk({tag, "_mem_be"}, mem_be, v.exp_be);
    chk({tag, "_mem_addr"}, mem_addr, v.addr);
    chk({tag, "_mem_wdata"}, mem_wdata, v.exp_wdata);
  endtask

  task automatic run_txn(input vec_t v);
    // IDLE: arbitration; stray mem_gnt/mem_rvalid must be ignored here.
    @(negedge clk);
    if_req = !v.is_data;
    d_req  = v.is_data;
    if (v.is_data) begin
      d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata; if_addr = 32'hBAD0_0000;
    end else begin
      if_addr = v.addr; d_we = 1'b1; d_be = 4'h5; d_addr = 32'hBAD0_0004; d_wdata = 32'hFFFF_FFFF;
    end
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hA5A5_A5A5;
    #1;
    chk("idle_mem_req", mem_req, 0);
    chk("idle_gnt", {if_gnt, d_gnt}, 0);
    chk("idle_rvalid", {if_rvalid, d_rvalid}, 0);
    // REQ under backpressure: payload stable, no grant.
    for (int i = 0; i < int'(v.stall); i++) begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b1;
      #1;
      chk_payload("stall", v);
      chk("stall_gnt", {if_gnt, d_gnt}, 0);
      chk("stall_rvalid", {if_rvalid, d_rvalid}, 0);
    end
    @(negedge clk);
    mem_gnt = 1'b1; mem_rvalid = 1'b0;
    #1;
    chk_payload("req", v);
    chk("req_if_gnt", if_gnt, !v.is_data);
    chk("req_d_gnt", d_gnt, v.is_data);
    // WAIT: response routed to owner only.
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = v.rdata;
    #1;
    chk("wait_mem_req", mem_req, 0);
    chk("wait_gnt", {if_gnt, d_gnt}, 0);
    chk("wait_if_rvalid", if_rvalid, !v.is_data);
    chk("wait_d_rvalid", d_rvalid, v.is_data);
    if (v.is_data) begin
      chk("wait_d_rdata", d_rdata, v.rdata);
      chk("wait_if_rdata_hold", if_rdata, last_if_rdata);
      last_d_rdata = v.rdata;
    end else begin
      chk("wait_if_rdata", if_rdata, v.rdata);
      chk("wait_d_rdata_hold", d_rdata, last_d_rdata);
      last_if_rdata = v.rdata;
    end
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5555_5555;
    #1;
    chk("post_rvalid", {if_rvalid, d_rvalid}, 0);
    chk("post_if_rdata", if_rdata, last_if_rdata);
    chk("post_d_rdata", d_rdata, last_d_rdata);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_we"}, mem_we, 0);
    chk({tag, "_mem_be"}, mem_be, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_gnt"}, {if_gnt, d_gnt}, 0);
    chk({tag, "_rvalid"}, {if_rvalid, d_rvalid}, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);
  endtask

  initial begin
    logic [9:0] exp_order;
    int         n_got;
    int         n_if_exp, n_d_exp;

    //           data  we    be     addr          wdata         rdata         stall we  be     wdata
    vecs[0] = '{1'b0, 1'b0, 4'h0,  32'h0000_0004, 32'h0,        32'h0020_E1B3, 0, 1'b0, 4'hF,  32'h0};
    vecs[1] = '{1'b1, 1'b1, 4'h3,  32'h0000_0100, 32'hDEAD_BEEF, 32'hCAFE_0001, 0, 1'b1, 4'h3,  32'hDEAD_BEEF};
    vecs[2] = '{1'b1, 1'b0, 4'hF,  32'h0000_0200, 32'h7777_7777, 32'h1234_5678, 5, 1'b0, 4'hF,  32'h7777_7777};
    vecs[3] = '{1'b0, 1'b0, 4'h0,  32'h0000_0008, 32'h0,        32'h00A0_0093, 2, 1'b0, 4'hF,  32'h0};
    vecs[4] = '{1'b0, 1'b0, 4'h0,  32'h0000_000C, 32'h0,        32'h0000_0013, 0, 1'b0, 4'hF,  32'h0};

    rst = 1'b0;
    if_req = 1'b0; if_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_be = '0; d_addr = '0; d_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #12;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    n_if_exp = 0;
    n_d_exp  = 0;
    for (int k = 0; k < NumVec; k++) begin
      run_txn(vecs[k]);
      if (vecs[k].is_data) n_d_exp++;
      else n_if_exp++;
    end
`ifdef MEM_PORT_ARBITER_STATS_EN
    chk("stat_if_cnt", stat_if_cnt, n_if_exp);
    chk("stat_d_cnt", stat_d_cnt, n_d_exp);
`endif

    // Contention: both held high, zero-wait memory. Bit k is 1 when grant k goes to data.
    exp_order = 10'b0111101111;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0020;
    d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h0000_0300; d_wdata = '0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1357_9BDF;
    n_got = 0;
    for (int cyc = 0; cyc < 60 && n_got < 10; cyc++) begin
      #1;
      if (if_gnt || d_gnt) begin
        chk($sformatf("contend_one_hot_%0d", n_got), {if_gnt, d_gnt} == 2'b11, 0);
        chk($sformatf("contend_order_%0d", n_got), d_gnt, exp_order[n_got]);
        chk($sformatf("contend_addr_%0d", n_got), mem_addr,
            exp_order[n_got] ? 32'h0000_0300 : 32'h0000_0020);
        n_got++;
      end
      @(negedge clk);
    end
    chk("contend_grant_count", n_got, 10);
    // Last grant was in REQ; this negedge is WAIT, so dropping the requests ends the sequence.
    if_req = 1'b0; d_req = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("contend_drain_req", mem_req, 0);

    // Async reset while a fetch waits for its response.
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0040; mem_gnt = 1'b1; mem_rvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_seq_gnt", if_gnt, 1);
    @(negedge clk);
    if_req = 1'b0;
    #1;
    chk("rst_seq_wait_addr", mem_addr, 32'h0000_0040);
    #1;
    rst = 1'b0;
    #1;
    chk_all_zero("async_rst");
    mem_rvalid = 1'b1; mem_rdata = 32'hABCD_0123;
    #1;
    chk("rst_rvalid_blocked", {if_rvalid, d_rvalid}, 0);
`ifdef MEM_PORT_ARBITER_STATS_EN
    chk("rst_stat_if", stat_if_cnt, 0);
    chk("rst_stat_d", stat_d_cnt, 0);
`endif
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("late_rvalid_if", if_rvalid, 0);
    chk("late_rvalid_d", d_rvalid, 0);
    chk("late_if_rdata", if_rdata, 0);
    @(negedge clk);
    mem_rvalid = 1'b0;
    #1;
    chk("late_idle_req", mem_req, 0);
    chk("late_idle_gnt", {if_gnt, d_gnt}, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
